// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: FSM states and shift directions.
package shift_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic SH_LEFT = 1'b0;
   localparam logic SH_ASR  = 1'b1;

endpackage

// File: rtl/iterative_shift_unit_shift_array.sv
// ShiftArray: single-step shifter, logical left (zero fill) or arithmetic right (sign fill).
module ShiftArray
   import shift_pkg::*;
#(
   parameter int nBit = 16
) (
   input  logic [nBit-1:0] i_a,
   input  logic            i_dir,
   output logic [nBit-1:0] o_y
);

   logic signed [nBit-1:0] w_a_s;

   assign w_a_s = $signed(i_a);
   assign o_y   = (i_dir == SH_ASR) ? $unsigned(w_a_s >>> 1) : {i_a[nBit-2:0], 1'b0};

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shift-by-N controller: iterates ShiftArray once per clock with a start/done handshake.
module iterative_shift_unit
   import shift_pkg::*;
#(
   parameter int nBit = 16,
   parameter int SHW  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [nBit-1:0] In,
   input  logic [SHW-1:0]  shamt,
   input  logic            sh_cond,
   output logic [nBit-1:0] result,
   output logic            busy,
   output logic            done
);

   state_t          r_state, w_state_nxt;
   logic [nBit-1:0] r_acc, w_acc_nxt;
   logic [SHW-1:0]  r_count, w_count_nxt;
   logic            r_dir, w_dir_nxt;
   logic [nBit-1:0] r_result, w_result_nxt;
   logic [nBit-1:0] w_shifted;

   ShiftArray #(.nBit(nBit)) u_shift_array (
      .i_a   (r_acc),
      .i_dir (r_dir),
      .o_y   (w_shifted)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_count_nxt  = r_count;
      w_dir_nxt    = r_dir;
      w_result_nxt = r_result;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_acc_nxt   = In;
               w_count_nxt = shamt;
               w_dir_nxt   = sh_cond;
               if (shamt != '0) begin
                  w_state_nxt = S_SHIFT;
               end else begin
                  w_state_nxt  = S_DONE;
                  w_result_nxt = In;
               end
            end
         end
         S_SHIFT: begin
            w_acc_nxt   = w_shifted;
            w_count_nxt = r_count - SHW'(1);
            // The last step lands on the same edge that enters DONE, so capture the shifter output directly.
            if (r_count == SHW'(1)) begin
               w_state_nxt  = S_DONE;
               w_result_nxt = w_shifted;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_count  <= '0;
         r_dir    <= SH_LEFT;
         r_result <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_count  <= w_count_nxt;
         r_dir    <= w_dir_nxt;
         r_result <= w_result_nxt;
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed self-checking bench for iterative_shift_unit with hand-computed expected results.
module tb_iterative_shift_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] In;
   logic [3:0]  shamt;
   logic        sh_cond;
   logic [15:0] result;
   logic        busy;
   logic        done;

   int n_checks;
   int n_fails;

   iterative_shift_unit #(.nBit(16), .SHW(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .In      (In),
      .shamt   (shamt),
      .sh_cond (sh_cond),
      .result  (result),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and watch it cycle by cycle. bump_cyc > 0 pulses a
   // competing start (In=0x0003, shamt=1) in that cycle, which must be ignored.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] sh,
                         input logic dir, input logic [15:0] exp_res, input int bump_cyc);
      int done_cyc;
      int n_done;
      int busy_bad;
      logic [15:0] res_at_done;
      done_cyc    = 0;
      n_done      = 0;
      busy_bad    = 0;
      res_at_done = '0;
      In      = a;
      shamt   = sh;
      sh_cond = dir;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= int'(sh) + 4; c++) begin
         if (done) begin
            n_done++;
            if (done_cyc == 0) begin
               done_cyc    = c;
               res_at_done = result;
            end
         end
         if (busy !== (c <= int'(sh) + 1)) busy_bad++;
         if (c == bump_cyc) begin
            In      = 16'h0003;
            shamt   = 4'd1;
            sh_cond = 1'b0;
            start   = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check_val({tag, "_latency"}, done_cyc, int'(sh) + 1);
      check_val({tag, "_ndone"}, n_done, 1);
      check_val({tag, "_busy"}, busy_bad, 0);
      check_val({tag, "_result"}, res_at_done, exp_res);
      check_val({tag, "_held"}, result, exp_res);
   endtask

   initial begin
      int n_done_after;
      n_checks = 0;
      n_fails  = 0;
      rst      = 1'b1;
      start    = 1'b0;
      In       = '0;
      shamt    = '0;
      sh_cond  = 1'b0;
      tick();
      tick();
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_result", result, 16'h0000);
      rst = 1'b0;
      tick();

      run_op("left3",   16'h0001, 4'd3,  1'b0, 16'h0008, 0);
      run_op("asr_neg", 16'h8000, 4'd4,  1'b1, 16'hF800, 0);
      run_op("asr_pos", 16'h7FF0, 4'd4,  1'b1, 16'h07FF, 0);
      run_op("zero_l",  16'hA5A5, 4'd0,  1'b0, 16'hA5A5, 0);
      run_op("zero_r",  16'hA5A5, 4'd0,  1'b1, 16'hA5A5, 0);
      run_op("max_l",   16'hFFFF, 4'd15, 1'b0, 16'h8000, 0);
      run_op("max_r",   16'hFFFF, 4'd15, 1'b1, 16'hFFFF, 0);
      run_op("busy_st", 16'h0001, 4'd5,  1'b0, 16'h0020, 2);

      // A queued request would surface as a late done pulse.
      n_done_after = 0;
      for (int c = 0; c < 6; c++) begin
         if (done) n_done_after++;
         tick();
      end
      check_val("busy_st_noqueue", n_done_after, 0);

      // Abort a shamt=8 request in cycle 3.
      In      = 16'h0001;
      shamt   = 4'd8;
      sh_cond = 1'b0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_val("abort_busy_pre", busy, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_result", result, 16'h0000);
      check_val("abort_done", done, 1'b0);
      n_done_after = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) n_done_after++;
         tick();
      end
      check_val("abort_nodone", n_done_after, 0);
      run_op("post_rst", 16'h0081, 4'd2, 1'b1, 16'h0020, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected $finish before 200000");
      $fatal(1);
   end

endmodule
